// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, read-source select type and address range check for reg_file_2r1w.
package regfile_pkg;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEPTH = 8;
   typedef enum logic [1:0] {SRC_ZERO, SRC_BYPASS, SRC_ARRAY} rd_src_t;
   function automatic logic addr_ok(input int unsigned addr, input int unsigned depth);
      return addr < depth;
   endfunction
endpackage

// File: rtl/mux_param_n_to_1.sv
// mux_param_n_to_1: N:1 word mux; a select beyond N-1 yields zero.
module mux_param_n_to_1 import regfile_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N = DEF_DEPTH,
   localparam int SW = $clog2(N)
) (
   input  logic [N-1:0][WIDTH-1:0] din,
   input  logic [SW-1:0]           sel,
   output logic [WIDTH-1:0]        dout
);
   assign dout = addr_ok(32'(sel), N) ? din[sel] : '0;
endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 1-write / 2-read register file with optional output registers,
// write-first bypass, synchronous bulk clear and hard-wired zero register.
module reg_file_2r1w import regfile_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter bit REG_OUT = 1'b0,
   parameter bit BYPASS = 1'b1,
   parameter bit ZERO_REG = 1'b0,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Clear,
   input  logic             W_wr,
   input  logic [AW-1:0]    W_addr,
   input  logic [WIDTH-1:0] W_data,
   input  logic             Rp_rd,
   input  logic [AW-1:0]    Rp_addr,
   output logic [WIDTH-1:0] Rp_data,
   input  logic             Rq_rd,
   input  logic [AW-1:0]    Rq_addr,
   output logic [WIDTH-1:0] Rq_data
);
   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic                        wr_ok;
   logic [1:0]                  rd;
   logic [1:0][AW-1:0]          ra;
   assign wr_ok = W_wr && addr_ok(32'(W_addr), DEPTH) && !(ZERO_REG && W_addr == '0);
   assign rd = {Rq_rd, Rp_rd};
   assign ra = {Rq_addr, Rp_addr};
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) mem <= '0;
      else if (Clear) mem <= '0;
      else if (wr_ok) mem[W_addr] <= W_data;
   for (genvar p = 0; p < 2; p++) begin : g_port
      rd_src_t          src;
      logic [WIDTH-1:0] arr;
      logic [WIDTH-1:0] eff;
      logic [WIDTH-1:0] data;
      mux_param_n_to_1 #(.WIDTH(WIDTH), .N(DEPTH)) u_mux (.din(mem), .sel(ra[p]), .dout(arr));
      // Reset forces zero here too so a bypassed write cannot leak out while held in reset
      always_comb begin
         src = (Reset || !addr_ok(32'(ra[p]), DEPTH) || (ZERO_REG && ra[p] == '0) || (BYPASS && Clear)) ? SRC_ZERO
             : (BYPASS && W_wr && W_addr == ra[p]) ? SRC_BYPASS : SRC_ARRAY;
         eff = src == SRC_BYPASS ? W_data : src == SRC_ARRAY ? arr : '0;
      end
      if (REG_OUT) begin : g_reg
         always_ff @(posedge Clk or posedge Reset)
            if (Reset) data <= '0;
            else if (rd[p]) data <= eff;
      end else begin : g_comb
         assign data = rd[p] ? eff : '0;
      end
   end
   assign Rp_data = g_port[0].data;
   assign Rq_data = g_port[1].data;
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: four configurations on shared inputs, checked against a behavioural model.
module tb_reg_file_2r1w;
   logic        clk = 1'b0, rst = 1'b1, clr = 1'b0, wr = 1'b0, rp = 1'b0, rq = 1'b0;
   logic [2:0]  wa = '0, rpa = '0, rqa = '0;
   logic [15:0] wd = '0;
   logic [15:0] o_p [4];
   logic [15:0] o_q [4];
   int          errors = 0, checks = 0;
   // configs: 0 default, 1 no bypass, 2 registered out, 3 zero reg with depth 6
   int          dep [4] = '{8, 8, 8, 6};
   bit          byp [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   bit          zr  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   logic [15:0] m [4][8];
   logic [15:0] qp = '0, qq = '0;

   always #5 clk = ~clk;

   reg_file_2r1w u0 (.Clk(clk), .Reset(rst), .Clear(clr), .W_wr(wr), .W_addr(wa), .W_data(wd),
      .Rp_rd(rp), .Rp_addr(rpa), .Rp_data(o_p[0]), .Rq_rd(rq), .Rq_addr(rqa), .Rq_data(o_q[0]));
   reg_file_2r1w #(.BYPASS(1'b0)) u1 (.Clk(clk), .Reset(rst), .Clear(clr), .W_wr(wr), .W_addr(wa), .W_data(wd),
      .Rp_rd(rp), .Rp_addr(rpa), .Rp_data(o_p[1]), .Rq_rd(rq), .Rq_addr(rqa), .Rq_data(o_q[1]));
   reg_file_2r1w #(.REG_OUT(1'b1)) u2 (.Clk(clk), .Reset(rst), .Clear(clr), .W_wr(wr), .W_addr(wa), .W_data(wd),
      .Rp_rd(rp), .Rp_addr(rpa), .Rp_data(o_p[2]), .Rq_rd(rq), .Rq_addr(rqa), .Rq_data(o_q[2]));
   reg_file_2r1w #(.DEPTH(6), .ZERO_REG(1'b1)) u3 (.Clk(clk), .Reset(rst), .Clear(clr), .W_wr(wr), .W_addr(wa), .W_data(wd),
      .Rp_rd(rp), .Rp_addr(rpa), .Rp_data(o_p[3]), .Rq_rd(rq), .Rq_addr(rqa), .Rq_data(o_q[3]));

   function automatic logic [15:0] eff(int c, logic [2:0] a);
      if (rst) return '0;
      if (int'(a) >= dep[c] || (zr[c] && a == 0)) return '0;
      if (byp[c] && clr) return '0;
      if (byp[c] && wr && wa == a) return wd;
      return m[c][a];
   endfunction

   task automatic model_zero();
      foreach (m[c, a]) m[c][a] = '0;
      qp = '0;
      qq = '0;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic r, input logic c, input logic w, input logic [2:0] a, input logic [15:0] d,
                        input logic pe, input logic [2:0] pa, input logic qe, input logic [2:0] qa);
      rst = r; clr = c; wr = w; wa = a; wd = d; rp = pe; rpa = pa; rq = qe; rqa = qa;
      if (r) model_zero();
      #2;
   endtask

   task automatic check_all();
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("p%0d a=%0d", c, rpa), o_p[c], c == 2 ? qp : (rp ? eff(c, rpa) : 16'h0));
         chk($sformatf("q%0d a=%0d", c, rqa), o_q[c], c == 2 ? qq : (rq ? eff(c, rqa) : 16'h0));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         if (rp) qp = eff(2, rpa);
         if (rq) qq = eff(2, rqa);
         for (int c = 0; c < 4; c++)
            if (clr) for (int a = 0; a < 8; a++) m[c][a] = '0;
            else if (wr && int'(wa) < dep[c] && !(zr[c] && wa == 0)) m[c][wa] = wd;
      end
      @(negedge clk);
   endtask

   task automatic step(input logic r, input logic c, input logic w, input logic [2:0] a, input logic [15:0] d,
                       input logic pe, input logic [2:0] pa, input logic qe, input logic [2:0] qa);
      drive(r, c, w, a, d, pe, pa, qe, qa);
      check_all();
      tick();
   endtask

   initial begin
      model_zero();
      @(negedge clk);
      step(1, 0, 0, 0, 0, 1, 0, 1, 0);
      for (int a = 0; a < 8; a++) step(0, 0, 0, 0, 0, 1, 3'(a), 1, 3'(7 - a));
      step(0, 0, 1, 3, 16'hA5A5, 0, 0, 0, 0);
      step(0, 0, 1, 7, 16'h1234, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 3, 1, 7);
      check_all();
      chk("wr_rd p", o_p[0], 16'hA5A5);
      chk("wr_rd q", o_q[0], 16'h1234);
      chk("depth6 r7", o_q[3], 16'h0000);
      tick();
      drive(0, 0, 0, 0, 0, 0, 3, 1, 7);
      check_all();
      chk("rd_off", o_p[0], 16'h0000);
      tick();
      drive(0, 0, 1, 5, 16'hBEEF, 1, 5, 1, 5);
      check_all();
      chk("bypass p", o_p[0], 16'hBEEF);
      chk("nobypass old", o_q[1], 16'h0000);
      tick();
      drive(0, 0, 0, 0, 0, 1, 5, 1, 5);
      check_all();
      chk("nobypass new", o_p[1], 16'hBEEF);
      chk("regout bypass", o_p[2], 16'hBEEF);
      tick();
      step(0, 0, 1, 2, 16'h0F0F, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 2, 0, 0);
      drive(0, 0, 1, 2, 16'h1111, 0, 2, 0, 0);
      check_all();
      chk("regout load", o_p[2], 16'h0F0F);
      tick();
      drive(0, 0, 0, 0, 0, 0, 2, 0, 0);
      check_all();
      chk("regout hold", o_p[2], 16'h0F0F);
      tick();
      step(0, 1, 1, 4, 16'h7777, 1, 4, 1, 4);
      drive(0, 0, 0, 0, 0, 1, 4, 1, 2);
      check_all();
      chk("clear r4", o_p[0], 16'h0000);
      chk("clear r2", o_q[0], 16'h0000);
      tick();
      step(0, 0, 1, 0, 16'hFFFF, 0, 0, 0, 0);
      step(0, 0, 1, 6, 16'h5555, 1, 0, 1, 6);
      drive(0, 0, 0, 0, 0, 1, 0, 1, 6);
      check_all();
      chk("zero r0", o_p[3], 16'h0000);
      chk("plain r0", o_p[0], 16'hFFFF);
      chk("depth6 a6", o_q[3], 16'h0000);
      tick();
      for (int a = 0; a < 6; a++) step(0, 0, 0, 0, 0, 1, 3'(a), 1, 3'(a));
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
              3'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
              $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)));
      drive(1, 0, 1, 1, 16'hABCD, 1, 1, 1, 1);
      check_all();
      chk("mid reset p", o_p[0], 16'h0000);
      chk("mid reset reg", o_q[2], 16'h0000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
Parametrised register file for the processor datapath. It generalises the fixed 16-bit 8:1 read mux into storage with one write port and two independent read ports (P and Q), each read port built on a parametrised N:1 mux. Optional features: registered read outputs, write-to-read bypass, synchronous bulk clear and a hard-wired zero register. It feeds the ALU A/B operands and takes ALU/memory results as write-back.

Parameters:
WIDTH, 16, data width in bits (>=1)
DEPTH, 8, number of registers (>=2; need not be a power of 2)
AW, $clog2(DEPTH), address width; derived, not overridden
REG_OUT, 0, 0 = combinational read; 1 = read data registered, 1-cycle latency
BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to that read port
ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes

Ports:
Clk      input   1      rising-edge clock
Reset    input   1      asynchronous, active-high reset
Clear    input   1      synchronous clear of all registers
W_wr     input   1      write enable
W_addr   input   AW     write address
W_data   input   WIDTH  write data
Rp_rd    input   1      port P read enable
Rp_addr  input   AW     port P address
Rp_data  output  WIDTH  port P data
Rq_rd    input   1      port Q read enable
Rq_addr  input   AW     port Q address
Rq_data  output  WIDTH  port Q data

Behaviour:
- Reset: asynchronous and active-high. While asserted, all DEPTH entries = 0 and Rp_data/Rq_data = 0. The deasserting edge has no effect; the first write can occur on the next rising Clk.
- Write: on rising Clk with W_wr=1, mem[W_addr] <= W_data.
  - W_addr >= DEPTH: write ignored.
  - ZERO_REG=1 and W_addr=0: write ignored.
- Clear: on rising Clk with Clear=1, all entries <= 0. Clear beats a simultaneous W_wr, so the write is dropped.
- Effective read value for a port with address A (priority order):
  1. 0 if A >= DEPTH, or if ZERO_REG=1 and A=0.
  2. Otherwise 0 if BYPASS=1 and Clear=1.
  3. Otherwise W_data if BYPASS=1, W_wr=1 and W_addr=A (write-first).
  4. Otherwise mem[A].
- REG_OUT=0:
  - Rx_data = effective value when Rx_rd=1, else 0. Purely combinational.
  - BYPASS=0: the value written becomes visible the cycle after the write edge.
- REG_OUT=1:
  - On rising Clk with Rx_rd=1, Rx_data <= effective value. With Rx_rd=0, Rx_data holds.
  - Latency 1 cycle. BYPASS=0 gives read-before-write, i.e. old data.
- Ports P and Q are fully independent. Both may read the same address in the same cycle, including the address being written.
- Reset asserted mid-operation: the register contents, and the output registers when REG_OUT=1, go to 0 immediately.

Decomposition:
- Package regfile_pkg:
  - default WIDTH/DEPTH constants
  - typedef for the read-source select (ZERO, BYPASS, ARRAY)
  - function returning the effective address range check
- Sub-module mux_param_n_to_1 #(WIDTH, N):
  - inputs: packed array of N words and a $clog2(N) select
  - out-of-range select yields 0
  - instantiated once per read port over the storage array
- Bypass, zero and output-register logic stays in reg_file_2r1w.

Test Plan:
- Reset with defaults (16x8, REG_OUT=0, BYPASS=1): assert Reset mid-run. Rp_data=Rq_data=0 immediately; reading all 8 addresses after release returns 0.
- Write then read: write 0xA5A5 to r3 and 0x1234 to r7. Next cycle Rp_addr=3, Rq_addr=7 -> Rp_data=0xA5A5, Rq_data=0x1234. Rp_rd=0 -> Rp_data=0.
- Bypass: W_wr=1, W_addr=5, W_data=0xBEEF, Rp_addr=Rq_addr=5 in the same cycle.
  - BYPASS=1: both outputs 0xBEEF that cycle.
  - BYPASS=0: both show the old value, then 0xBEEF next cycle.
- REG_OUT=1: r2=0x0F0F; Rp_rd=1, Rp_addr=2 at edge N -> Rp_data=0x0F0F after edge N. Drop Rp_rd and change r2 to 0x1111 -> Rp_data holds 0x0F0F.
- Clear vs write: Clear=1 with W_wr=1, W_addr=4, W_data=0x7777 -> next cycle r4 reads 0 and every register reads 0.
- ZERO_REG=1, DEPTH=6 (AW=3): write 0xFFFF to r0 -> r0 reads 0. Read/write at addr 6 or 7 -> read 0, r0..r5 unchanged.
